// File: rtl/clock_run_ctrl.sv
// Run-control sequencer: divides raw_clk into the CPU clock with a matching rising-edge enable,
// under free-run, button-stepped or breakpoint-halt control. Define CYCLE_COUNTER_EN to build cyc_cnt.
module clock_run_ctrl #(
    parameter int DIV_SHIFT  = 4,
    parameter int DEB_CYCLES = 50000,
    parameter int DEB_W      = 16
) (
    input  logic        raw_clk,
    input  logic        rst,
    input  logic        auto_en,
    input  logic        manual_btn,
    input  logic [7:0]  div_sel,
    input  logic [7:0]  step_n,
    input  logic        halt_req,
    input  logic        resume,
    output logic        clk,
    output logic        ce,
    output logic [1:0]  state,
    output logic        halted,
    output logic [15:0] cyc_cnt
);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_e;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    state_e            state_q, state_d;
    logic              clk_q, clk_d;
    logic              ce_q, ce_d;
    logic              halted_q, halted_d;
    logic [31:0]       div_cnt_q, div_cnt_d;
    logic [7:0]        step_cnt_q, step_cnt_d;
    logic              btn_s1_q, btn_s1_d;
    logic              btn_s2_q, btn_s2_d;
    logic              btn_db_q, btn_db_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              press_q, press_d;
    logic              halt_lat_q, halt_lat_d;
    logic [31:0]       limit;
    logic              boundary;
    logic              rise;
    logic              fall;

    always_comb begin
        btn_s1_d  = manual_btn;
        btn_s2_d  = btn_s1_q;
        btn_db_d  = btn_db_q;
        deb_cnt_d = '0;
        // The counter only advances while the synchronised level disagrees with the accepted one.
        if (btn_s2_q != btn_db_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                btn_db_d = btn_s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
        press_d = btn_db_d & ~btn_db_q;

        halt_lat_d = halt_req ? 1'b1 : (resume ? 1'b0 : halt_lat_q);

        limit    = ({24'b0, div_sel} + 32'd1) << DIV_SHIFT;
        boundary = (div_cnt_q >= limit - 32'd1);
        rise     = boundary & ~clk_q;
        fall     = boundary & clk_q;

        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        clk_d      = clk_q;
        ce_d       = 1'b0;
        step_cnt_d = step_cnt_q;

        case (state_q)
            ST_HALT: begin
                div_cnt_d = '0;
                clk_d     = 1'b0;
                if (auto_en && !halt_lat_q) begin
                    state_d = ST_RUN;
                end else if (!auto_en && press_q) begin
                    state_d    = ST_STEP;
                    step_cnt_d = (step_n == 8'd0) ? 8'd1 : step_n;
                end
            end
            ST_RUN, ST_STEP: begin
                if (boundary) begin
                    div_cnt_d = '0;
                    clk_d     = ~clk_q;
                    ce_d      = ~clk_q;
                end else begin
                    div_cnt_d = div_cnt_q + 32'd1;
                end
                // Leaving only on a falling toggle guarantees clk rests low in HALT.
                if (state_q == ST_RUN) begin
                    if (fall && (!auto_en || halt_lat_q)) state_d = ST_HALT;
                end else begin
                    if (rise) step_cnt_d = step_cnt_q - 8'd1;
                    if (fall && (step_cnt_q == 8'd0 || halt_lat_q)) state_d = ST_HALT;
                end
            end
            default: begin
                state_d   = ST_HALT;
                div_cnt_d = '0;
                clk_d     = 1'b0;
            end
        endcase

        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge raw_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_HALT;
            clk_q      <= 1'b0;
            ce_q       <= 1'b0;
            halted_q   <= 1'b1;
            div_cnt_q  <= '0;
            step_cnt_q <= '0;
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            btn_db_q   <= 1'b0;
            deb_cnt_q  <= '0;
            press_q    <= 1'b0;
            halt_lat_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_q      <= clk_d;
            ce_q       <= ce_d;
            halted_q   <= halted_d;
            div_cnt_q  <= div_cnt_d;
            step_cnt_q <= step_cnt_d;
            btn_s1_q   <= btn_s1_d;
            btn_s2_q   <= btn_s2_d;
            btn_db_q   <= btn_db_d;
            deb_cnt_q  <= deb_cnt_d;
            press_q    <= press_d;
            halt_lat_q <= halt_lat_d;
        end
    end

`ifdef CYCLE_COUNTER_EN
    logic [15:0] cyc_cnt_q, cyc_cnt_d;

    always_comb begin
        cyc_cnt_d = cyc_cnt_q + {15'd0, ce_d};
    end

    always_ff @(posedge raw_clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    assign cyc_cnt = cyc_cnt_q;
`else
    assign cyc_cnt = 16'd0;
`endif

    assign clk    = clk_q;
    assign ce     = ce_q;
    assign state  = state_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_clock_run_ctrl.sv
// Scoreboard bench for clock_run_ctrl: expected ce cycles are queued as stimulus is applied
// and matched against the ce pulses the monitor captures.
module tb_clock_run_ctrl;

    logic        raw_clk = 1'b0;
    logic        rst = 1'b0;
    logic        auto_en = 1'b0;
    logic        manual_btn = 1'b0;
    logic [7:0]  div_sel = 8'd0;
    logic [7:0]  step_n = 8'd1;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic        clk;
    logic        ce;
    logic [1:0]  state;
    logic        halted;
    logic [15:0] cyc_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ce_total = 0;
    int obs_q[$];
    int exp_q[$];

    clock_run_ctrl #(
        .DIV_SHIFT (4),
        .DEB_CYCLES(4),
        .DEB_W     (16)
    ) dut (
        .raw_clk   (raw_clk),
        .rst       (rst),
        .auto_en   (auto_en),
        .manual_btn(manual_btn),
        .div_sel   (div_sel),
        .step_n    (step_n),
        .halt_req  (halt_req),
        .resume    (resume),
        .clk       (clk),
        .ce        (ce),
        .state     (state),
        .halted    (halted),
        .cyc_cnt   (cyc_cnt)
    );

    always #5 raw_clk = ~raw_clk;

    always @(posedge raw_clk) cyc <= cyc + 1;

    // Monitor: records the cycle index of every ce pulse seen out of reset.
    always @(negedge raw_clk) begin
        if (rst !== 1'b1) begin
            ce_total = 0;
        end else if (ce === 1'b1) begin
            obs_q.push_back(cyc);
            ce_total = ce_total + 1;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge raw_clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(3);
        checks++; if (clk !== 1'b0)    begin errors++; $display("FAIL reset_clk: got %b, required 0", clk); end
        checks++; if (ce !== 1'b0)     begin errors++; $display("FAIL reset_ce: got %b, required 0", ce); end
        checks++; if (state !== 2'd0)  begin errors++; $display("FAIL reset_state: got %0d, required 0", state); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL reset_halted: got %b, required 1", halted); end
        checks++; if (cyc_cnt !== 16'd0) begin errors++; $display("FAIL reset_cyc_cnt: got %0d, required 0", cyc_cnt); end
        rst = 1'b1;
        tick(4);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_idle_state: got %0d, required 0", state); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_run(input logic [7:0] sel, input int lim, input string nm);
        int e;
        int h;
        int ev;
        int ov;
        int exp_cc;
        bit found;
        obs_q.delete();
        exp_q.delete();
        div_sel = sel;
        auto_en = 1'b1;
        found = 1'b0;
        e = 0;
        for (int i = 0; i < 5 && !found; i++) begin
            tick(1);
            if (state === 2'd1) begin found = 1'b1; e = cyc; end
        end
        checks++; if (!found) begin errors++; $display("FAIL %s run_entry: state %0d, required 1", nm, state); end
        exp_q.push_back(e + lim);
        exp_q.push_back(e + 3 * lim);
        exp_q.push_back(e + 5 * lim);
        while (cyc < e + 2 * lim - 1) tick(1);
        checks++; if (clk !== 1'b1) begin errors++; $display("FAIL %s clk_high: got %b, required 1", nm, clk); end
        tick(1);
        checks++; if (clk !== 1'b0) begin errors++; $display("FAIL %s clk_low: got %b, required 0", nm, clk); end
        while (cyc < e + 5 * lim + 2) tick(1);
        auto_en = 1'b0;
        found = 1'b0;
        h = 0;
        for (int i = 0; i < 2 * lim + 4 && !found; i++) begin
            tick(1);
            if (halted === 1'b1) begin found = 1'b1; h = cyc; end
        end
        checks++; if (!found || h != e + 6 * lim) begin errors++; $display("FAIL %s halt_time: got cycle %0d, required %0d", nm, h, e + 6 * lim); end
        checks++; if (clk !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL %s halt_rest: clk %b state %0d, required 0/0", nm, clk, state); end
        tick(2 * lim);
        while (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL %s ce_time: no ce seen, required cycle %0d", nm, ev);
            end else begin
                ov = obs_q.pop_front();
                if (ov != ev) begin errors++; $display("FAIL %s ce_time: got cycle %0d, required %0d", nm, ov, ev); end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL %s extra_ce: got %0d extra pulses, required 0", nm, obs_q.size()); end
        obs_q.delete();
`ifdef CYCLE_COUNTER_EN
        exp_cc = ce_total;
`else
        exp_cc = 0;
`endif
        checks++; if (cyc_cnt !== exp_cc[15:0]) begin errors++; $display("FAIL %s cyc_cnt: got %0d, required %0d", nm, cyc_cnt, exp_cc[15:0]); end
        div_sel = 8'd0;
    endtask

    task automatic test_step(input logic [7:0] n, input int pulses, input bit second_press, input string nm);
        int start;
        int halt_at;
        int base;
        int ev;
        int ov;
        int last;
        bit saw_step;
        obs_q.delete();
        exp_q.delete();
        auto_en = 1'b0;
        div_sel = 8'd0;
        step_n = n;
        for (int k = 0; k < pulses; k++) exp_q.push_back(32 * k);
        start = cyc;
        saw_step = 1'b0;
        halt_at = -1;
        manual_btn = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (i == 9) manual_btn = 1'b0;
            if (second_press && i == 40) manual_btn = 1'b1;
            if (second_press && i == 50) manual_btn = 1'b0;
            if (state === 2'd2) saw_step = 1'b1;
            else if (saw_step && state === 2'd0 && halt_at < 0) halt_at = cyc;
        end
        tick(2);
        checks++; if (!saw_step) begin errors++; $display("FAIL %s step_entry: state never 2, required 2", nm); end
        checks++; if (obs_q.size() != pulses) begin errors++; $display("FAIL %s ce_count: got %0d, required %0d", nm, obs_q.size(), pulses); end
        base = (obs_q.size() > 0) ? obs_q[0] : 0;
        last = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1] : 0;
        checks++; if (obs_q.size() == 0 || base - start < 16 || base - start > 40) begin errors++; $display("FAIL %s first_ce: got offset %0d, required 16..40", nm, base - start); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev = exp_q.pop_front();
            ov = obs_q.pop_front();
            checks++;
            if (ov - base != ev) begin errors++; $display("FAIL %s ce_spacing: got %0d, required %0d", nm, ov - base, ev); end
        end
        checks++; if (halt_at != last + 16) begin errors++; $display("FAIL %s halt_time: got cycle %0d, required %0d", nm, halt_at, last + 16); end
        checks++; if (state !== 2'd0 || clk !== 1'b0) begin errors++; $display("FAIL %s end_rest: state %0d clk %b, required 0/0", nm, state, clk); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_halt();
        int t1;
        int e;
        int h;
        int ev;
        int ov;
        bit found;
        obs_q.delete();
        exp_q.delete();
        div_sel = 8'd0;
        auto_en = 1'b1;
        found = 1'b0;
        t1 = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            if (clk === 1'b1) begin found = 1'b1; t1 = cyc; end
        end
        checks++; if (!found) begin errors++; $display("FAIL halt_first_rise: clk stayed %b, required 1", clk); end
        exp_q.push_back(t1);
        tick(2);
        halt_req = 1'b1;
        tick(1);
        halt_req = 1'b0;
        while (cyc < t1 + 15) tick(1);
        checks++; if (halted !== 1'b0 || clk !== 1'b1) begin errors++; $display("FAIL halt_early: halted %b clk %b, required 0/1", halted, clk); end
        tick(1);
        checks++; if (halted !== 1'b1 || clk !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL halt_on_fall: halted %b clk %b state %0d, required 1/0/0", halted, clk, state); end
        tick(40);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL halt_hold: state %0d, required 0", state); end
        resume = 1'b1;
        tick(1);
        resume = 1'b0;
        found = 1'b0;
        e = 0;
        for (int i = 0; i < 5 && !found; i++) begin
            tick(1);
            if (state === 2'd1) begin found = 1'b1; e = cyc; end
        end
        checks++; if (!found) begin errors++; $display("FAIL resume_run: state %0d, required 1", state); end
        exp_q.push_back(e + 16);
        while (cyc < e + 17) tick(1);
        halt_req = 1'b1;
        resume = 1'b1;
        tick(1);
        halt_req = 1'b0;
        resume = 1'b0;
        found = 1'b0;
        h = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            if (halted === 1'b1) begin found = 1'b1; h = cyc; end
        end
        checks++; if (!found || h != e + 32) begin errors++; $display("FAIL set_wins_halt: got cycle %0d, required %0d", h, e + 32); end
        tick(20);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL set_wins_hold: state %0d, required 0", state); end
        auto_en = 1'b0;
        resume = 1'b1;
        tick(1);
        resume = 1'b0;
        tick(3);
        while (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL halt ce_time: no ce seen, required cycle %0d", ev);
            end else begin
                ov = obs_q.pop_front();
                if (ov != ev) begin errors++; $display("FAIL halt ce_time: got cycle %0d, required %0d", ov, ev); end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL halt extra_ce: got %0d extra pulses, required 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_bounce();
        bit left_halt;
        obs_q.delete();
        auto_en = 1'b0;
        step_n = 8'd1;
        left_halt = 1'b0;
        for (int r = 0; r < 6; r++) begin
            manual_btn = 1'b1;
            for (int i = 0; i < 2; i++) begin tick(1); if (state !== 2'd0) left_halt = 1'b1; end
            manual_btn = 1'b0;
            for (int i = 0; i < 2; i++) begin tick(1); if (state !== 2'd0) left_halt = 1'b1; end
        end
        for (int i = 0; i < 40; i++) begin tick(1); if (state !== 2'd0) left_halt = 1'b1; end
        checks++; if (left_halt) begin errors++; $display("FAIL bounce_state: left HALT, required HALT throughout"); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL bounce_ce: got %0d pulses, required 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_reset_mid_step();
        bit found;
        obs_q.delete();
        auto_en = 1'b0;
        step_n = 8'd3;
        manual_btn = 1'b1;
        tick(10);
        manual_btn = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick(1);
            if (clk === 1'b1) found = 1'b1;
        end
        checks++; if (!found || state !== 2'd2) begin errors++; $display("FAIL midstep_setup: clk %b state %0d, required 1/2", clk, state); end
        tick(3);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (clk !== 1'b0)    begin errors++; $display("FAIL async_rst_clk: got %b, required 0", clk); end
        checks++; if (state !== 2'd0)  begin errors++; $display("FAIL async_rst_state: got %0d, required 0", state); end
        checks++; if (ce !== 1'b0)     begin errors++; $display("FAIL async_rst_ce: got %b, required 0", ce); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL async_rst_halted: got %b, required 1", halted); end
        checks++; if (cyc_cnt !== 16'd0) begin errors++; $display("FAIL async_rst_cyc_cnt: got %0d, required 0", cyc_cnt); end
        tick(2);
        rst = 1'b1;
        obs_q.delete();
        tick(40);
        checks++; if (state !== 2'd0 || obs_q.size() != 0) begin errors++; $display("FAIL post_rst_idle: state %0d ce %0d, required 0/0", state, obs_q.size()); end
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_run(8'd0, 16, "run_div0");
        test_run(8'd1, 32, "run_div1");
        test_step(8'd3, 3, 1'b1, "step3");
        test_step(8'd0, 1, 1'b0, "step0");
        test_halt();
        test_bounce();
        test_reset_mid_step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_run_ctrl.md
Name: clock_run_ctrl

Overview:
Run-control sequencer for the CPU clock. It generates the divided CPU clock `clk` and a matching one-cycle enable `ce` from `raw_clk`. The CPU clock can be free-running, single- or multi-stepped from a debounced push-button, or halted by a breakpoint request. It sits between the board oscillator and the CPU core and replaces direct switch-driven division with a controlled FSM.

Parameters:
DIV_SHIFT, 4, half-period = (div_sel+1) << DIV_SHIFT raw_clk cycles
DEB_CYCLES, 50000, raw_clk cycles the button must stay stable before the change is accepted
DEB_W, 16, debounce counter width; must hold DEB_CYCLES

Ports:
raw_clk  in  1  board clock; all logic is on its rising edge
rst  in  1  asynchronous, active-low reset
auto_en  in  1  level: 1 = free-run mode, 0 = manual mode
manual_btn  in  1  raw, asynchronous push-button; active high
div_sel  in  8  divider select; sampled at each half-period boundary
step_n  in  8  CPU rising edges delivered per accepted press; 0 is treated as 1
halt_req  in  1  breakpoint halt request; sampled every raw_clk cycle and latched
resume  in  1  one-cycle pulse; clears the halt latch
clk  out  1  divided CPU clock level
ce  out  1  one raw_clk pulse on the cycle clk goes 0->1
state  out  2  0=HALT, 1=RUN, 2=STEP
halted  out  1  1 while state==HALT
cyc_cnt  out  16  count of ce pulses (optional feature)

Behaviour:
- Reset (rst=0, async): state=HALT, clk=0, ce=0, halted=1, cyc_cnt=0. Divider, step, and debounce counters clear; halt latch clears; button synchroniser clears to 0.
- Button path:
  - 2-flop synchroniser, then debounce counter. btn_db changes only after DEB_CYCLES consecutive cycles of a stable differing value.
  - `press` = one-cycle pulse on the btn_db 0->1 transition.
- Divider:
  - Runs only in RUN/STEP; held at 0 in HALT.
  - Limit L = ({24'b0,div_sel}+1) << DIV_SHIFT, computed at 32 bits with no overflow.
  - The cycle the counter reaches L-1: counter=0 and clk toggles. Otherwise counter+1.
  - On a 0->1 toggle, ce=1 for that same cycle; ce is 0 otherwise.
- Halt latch: set by halt_req=1; cleared by resume=1. Simultaneous set and clear in the same cycle: set wins.
- FSM (one transition per cycle):
  - HALT->RUN: auto_en=1 and latch clear. The divider starts from 0; the first ce comes L cycles later.
  - HALT->STEP: auto_en=0 and press. The step counter loads max(step_n,1).
  - RUN->HALT: (auto_en=0 or latch set), taken only on the cycle clk toggles 1->0. If clk is already 0, taken on the next 1->0 toggle. clk therefore always rests at 0 in HALT.
  - STEP: each ce decrements the step counter. After the final rising edge, the FSM goes to HALT on the following 1->0 toggle. A latch set during STEP also ends the step at the next 1->0 toggle. A press during STEP is ignored.
- auto_en going 1 while in STEP: the step completes first, then the HALT->RUN rule applies.
- A press while auto_en=1 is ignored.
- A div_sel change mid half-period takes effect at the next boundary. If the counter is already ≥ new L-1, the boundary fires next cycle.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
CYCLE_COUNTER_EN:
- Defined: cyc_cnt increments by 1 on every ce, wraps at 16'hFFFF->0, and clears only on reset.
- Undefined: cyc_cnt is tied to 0 and no counter is synthesised.

Test Plan:
- Reset, then auto_en=1, div_sel=0, DIV_SHIFT=4 -> clk toggles every 16 raw cycles; first ce 16 cycles after RUN entry; ce period 32 cycles.
- auto_en=0, step_n=3, DEB_CYCLES=4 bench override, button held for 10 cycles -> exactly 3 ce pulses, then state=HALT with clk=0. A second press during STEP yields no extra pulses.
- step_n=0, one press -> exactly 1 ce.
- RUN, halt_req pulsed while clk=1 -> halted=1 at the next 1->0 toggle with no further ce. resume with auto_en=1 -> RUN; next ce 16 cycles later.
- Button bouncing with pulses shorter than DEB_CYCLES -> no press and state stays HALT. halt_req and resume in the same cycle -> latch set.
- Assert rst mid-STEP at clk=1 -> clk=0, state=HALT, ce=0 immediately. With CYCLE_COUNTER_EN, preload to 16'hFFFF and one ce -> cyc_cnt=0.
